// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces three active-low keys, then runs
// the IDLE/RUN/PAUSE/LAP state machine and the tick prescaler for the digit counters.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       fastclock,
  input  logic       resetn,
  input  logic       key_startstop,
  input  logic       key_lap,
  input  logic       key_clear,
  output logic       tick,
  output logic       clear_n,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  // Key index: 0 = startstop, 1 = lap, 2 = clear
  logic [2:0] keys_raw;
  logic [2:0] press;

  assign keys_raw = {key_clear, key_lap, key_startstop};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic          level_prev_reg;
      logic          press_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge fastclock) begin
        if (!resetn) begin
          sync1_reg      <= 1'b1;
          sync2_reg      <= 1'b1;
          level_reg      <= 1'b1;
          level_prev_reg <= 1'b1;
          press_reg      <= 1'b0;
          cnt_reg        <= '0;
        end else begin
          sync1_reg      <= keys_raw[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level_reg;
          press_reg      <= level_prev_reg & ~level_reg;
          // Count consecutive samples that disagree with the accepted level
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic          ev_startstop;
  logic          ev_lap;
  logic          ev_clear;
  state_t        state_reg;
  state_t        state_next;
  logic          clear_pulse;
  logic [PW-1:0] prescaler_reg;

  assign ev_startstop = press[0];
  assign ev_lap       = press[1];
  assign ev_clear     = press[2];

  // Events not applicable in the current state are filtered before priority applies
  always_comb begin
    state_next  = state_reg;
    clear_pulse = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ev_clear)          clear_pulse = 1'b1;
        else if (ev_startstop) state_next  = RUN;
      end
      RUN: begin
        if (ev_startstop) state_next = PAUSE;
        else if (ev_lap)  state_next = LAP;
      end
      PAUSE: begin
        if (ev_clear) begin
          state_next  = IDLE;
          clear_pulse = 1'b1;
        end else if (ev_startstop) begin
          state_next = RUN;
        end
      end
      LAP: begin
        if (ev_startstop) state_next = PAUSE;
        else if (ev_lap)  state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      clear_n       <= 1'b1;
      freeze        <= 1'b0;
      running       <= 1'b0;
      tick          <= 1'b0;
      prescaler_reg <= '0;
    end else begin
      state_reg <= state_next;
      clear_n   <= ~clear_pulse;
      freeze    <= (state_next == LAP);
      running   <= (state_next == RUN) || (state_next == LAP);
      tick      <= 1'b0;
      if (state_reg == RUN || state_reg == LAP) begin
        tick <= (prescaler_reg == PRESC_LAST);
        if (prescaler_reg == PRESC_LAST) prescaler_reg <= '0;
        else                             prescaler_reg <= prescaler_reg + 1'b1;
      end else if (state_next == IDLE) begin
        prescaler_reg <= '0;
      end
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected state changes, ticks and clear
// pulses are queued with their edge numbers as keys are pressed, then matched.
module tb_stopwatch_ctrl;
  localparam int TD = 10;
  localparam int DB = 4;
  localparam int LAT = DB + 4;  // negedge drive to state-update edge number

  logic       fastclock = 1'b0;
  logic       resetn = 1'b0;
  logic       ks = 1'b1;
  logic       kl = 1'b1;
  logic       kc = 1'b1;
  logic       tick;
  logic       clear_n;
  logic       freeze;
  logic       running;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .fastclock    (fastclock),
    .resetn       (resetn),
    .key_startstop(ks),
    .key_lap      (kl),
    .key_clear    (kc),
    .tick         (tick),
    .clear_n      (clear_n),
    .freeze       (freeze),
    .running      (running),
    .state        (state)
  );

  always #5 fastclock = ~fastclock;

  int cyc = 0;
  always @(posedge fastclock) cyc++;

  typedef struct {
    int         at;
    logic [1:0] st;
  } st_exp_t;

  st_exp_t    st_q[$];
  int         tick_q[$];
  int         clr_q[$];
  int         tests = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  logic [1:0] last_state = 2'b00;

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  always @(negedge fastclock) begin
    if (mon_en) begin
      if (state !== last_state) begin
        if (st_q.size() == 0) begin
          check("state_unexpected", int'(state), -1);
        end else begin
          st_exp_t e;
          e = st_q.pop_front();
          $display("[TB] cycle %0d state %0d -> %0d", cyc, last_state, state);
          check("state_cycle", cyc, e.at);
          check("state_value", int'(state), int'(e.st));
          check("freeze", int'(freeze), int'(e.st == 2'b11));
          check("running", int'(running), int'(e.st == 2'b01 || e.st == 2'b11));
        end
        last_state = state;
      end
      if (tick === 1'b1) begin
        $display("[TB] cycle %0d tick", cyc);
        if (tick_q.size() == 0) check("tick_unexpected", cyc, -1);
        else check("tick_cycle", cyc, tick_q.pop_front());
      end
      if (clear_n !== 1'b1) begin
        $display("[TB] cycle %0d clear_n low", cyc);
        if (clr_q.size() == 0) check("clear_unexpected", cyc, -1);
        else check("clear_cycle", cyc, clr_q.pop_front());
      end
    end
  end

  // Ticks expected while running from edge t0 (prescaler p0) until the edge t_end that leaves RUN/LAP
  task automatic add_ticks(input int t0, input int p0, input int t_end, output int p_out);
    for (int e = t0 + TD - p0; e <= t_end; e += TD) tick_q.push_back(e);
    p_out = (p0 + (t_end - t0)) % TD;
  endtask

  // Press the keys in mask {clear,lap,startstop} so the event acts at edge 'target'
  task automatic press_for(input logic [2:0] mask, input int target, input logic [1:0] exp_st,
                           input bit changes, input bit clr);
    st_exp_t e;
    while (cyc < target - LAT) @(negedge fastclock);
    if (cyc != target - LAT) check("schedule", cyc, target - LAT);
    if (mask[0]) ks = 1'b0;
    if (mask[1]) kl = 1'b0;
    if (mask[2]) kc = 1'b0;
    if (changes) begin
      e.at = target;
      e.st = exp_st;
      st_q.push_back(e);
    end
    if (clr) clr_q.push_back(target);
    repeat (10) @(negedge fastclock);
    ks = 1'b1;
    kl = 1'b1;
    kc = 1'b1;
    repeat (10) @(negedge fastclock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int p;
    int t1, t3, pz, t4, t5;
    st_exp_t e;

    // Reset values; startstop is already held low through reset
    ks = 1'b0;
    repeat (3) @(negedge fastclock);
    check("rst_state", int'(state), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_clear_n", int'(clear_n), 1);
    check("rst_freeze", int'(freeze), 0);
    check("rst_running", int'(running), 0);
    check("rst_prescaler", int'(dut.prescaler_reg), 0);

    // Key held through reset release counts as a press
    mon_en = 1'b1;
    resetn = 1'b1;
    t1 = cyc + LAT;
    e.at = t1;
    e.st = 2'b01;
    st_q.push_back(e);
    add_ticks(t1, 0, t1 + 36, p);
    repeat (10) @(negedge fastclock);
    ks = 1'b1;
    repeat (10) @(negedge fastclock);

    // Pause with prescaler at 6, resume 50 cycles later
    press_for(3'b001, t1 + 36, 2'b10, 1'b1, 1'b0);
    t3 = t1 + 86;
    add_ticks(t3, p, t3 + 115, p);
    press_for(3'b001, t3, 2'b01, 1'b1, 1'b0);

    // Lap view and back, clear ignored while running
    press_for(3'b010, t3 + 25, 2'b11, 1'b1, 1'b0);
    press_for(3'b010, t3 + 55, 2'b01, 1'b1, 1'b0);
    press_for(3'b100, t3 + 85, 2'b01, 1'b0, 1'b0);
    check("clear_in_run_state", int'(state), 1);
    press_for(3'b001, t3 + 115, 2'b10, 1'b1, 1'b0);
    pz = t3 + 115;

    // Clear from PAUSE, then a fresh run starts from prescaler 0
    press_for(3'b100, pz + 30, 2'b00, 1'b1, 1'b1);
    check("clear_prescaler", int'(dut.prescaler_reg), 0);
    t4 = pz + 60;
    add_ticks(t4, 0, t4 + 26, p);
    press_for(3'b001, t4, 2'b01, 1'b1, 1'b0);
    press_for(3'b001, t4 + 26, 2'b10, 1'b1, 1'b0);

    // Simultaneous clear and startstop in PAUSE: clear wins
    press_for(3'b101, t4 + 56, 2'b00, 1'b1, 1'b1);
    check("clear_wins_prescaler", int'(dut.prescaler_reg), 0);
    // Clear in IDLE pulses clear_n without a state change
    press_for(3'b100, t4 + 86, 2'b00, 1'b0, 1'b1);

    // Bounce shorter than the debounce window gives no event
    for (int i = 0; i < 10; i++) begin
      ks = ~ks;
      repeat (2) @(negedge fastclock);
    end
    ks = 1'b1;
    repeat (30) @(negedge fastclock);
    check("bounce_state", int'(state), 0);

    // Reset in the middle of RUN
    t5 = cyc + LAT;
    add_ticks(t5, 0, t5 + 14, p);
    press_for(3'b001, t5, 2'b01, 1'b1, 1'b0);
    while (cyc < t5 + 14) @(negedge fastclock);
    resetn = 1'b0;
    e.at = t5 + 15;
    e.st = 2'b00;
    st_q.push_back(e);
    @(negedge fastclock);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_tick", int'(tick), 0);
    check("mid_rst_clear_n", int'(clear_n), 1);
    check("mid_rst_freeze", int'(freeze), 0);
    check("mid_rst_running", int'(running), 0);
    check("mid_rst_prescaler", int'(dut.prescaler_reg), 0);
    @(negedge fastclock);
    resetn = 1'b1;
    repeat (20) @(negedge fastclock);

    check("state_q_left", st_q.size(), 0);
    check("tick_q_left", tick_q.size(), 0);
    check("clear_q_left", clr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
